lfsr_burst_ctrl: RTL

//  Sequencer for a 19-bit XNOR-feedback PRBS generator. Loads a seed, emits

---
 rtl/lfsr_burst_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: seedable 19-bit XNOR PRBS source with a burst sequencer.
// Loads a seed, streams burst_len PRBS bits over valid/ready, and pulses
// done, wrap and seed_err as registered one-cycle flags.
module lfsr_burst_ctrl #(
  parameter int               WIDTH = 19,
  parameter logic [WIDTH-1:0] TAPS  = 19'h40023,
  parameter logic [WIDTH-1:0] SEED  = 19'h55555,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             seed_err,
  output logic [WIDTH-1:0] lfsr_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // One XNOR-feedback step: shift left, feedback enters at bit 0.
  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] cur);
    lfsr_advance = {cur[WIDTH-2:0], ~^(cur & TAPS)};
  endfunction

  // All-ones is the XNOR lockup state and must never be loaded.
  function automatic logic seed_is_lockup(input logic [WIDTH-1:0] val);
    seed_is_lockup = &val;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] lfsr_r, lfsr_s;
  logic [WIDTH-1:0] start_val_r, start_val_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             done_r, done_s;
  logic             wrap_r, wrap_s;
  logic             seed_err_r, seed_err_s;
  logic [WIDTH-1:0] next_lfsr_s;
  logic [WIDTH-1:0] load_val_s;
  logic             seed_bad_s;

  assign next_lfsr_s = lfsr_advance(lfsr_r);
  assign seed_bad_s  = seed_is_lockup(seed_in);
  assign load_val_s  = seed_bad_s ? SEED : seed_in;

  // Next-state, datapath and pulse-flag decode for the burst sequencer.
  always_comb begin
    state_s     = state_r;
    lfsr_s      = lfsr_r;
    start_val_s = start_val_r;
    cnt_s       = cnt_r;
    done_s      = 1'b0;
    wrap_s      = 1'b0;
    seed_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_s     = load_val_s;
          seed_err_s = seed_bad_s;
        end else begin
          lfsr_s     = lfsr_r;
        end
        if (start) begin
          // Burst begins from whatever the LFSR holds entering RUN,
          // including a seed loaded in this same cycle.
          cnt_s       = burst_len;
          start_val_s = lfsr_s;
          if (burst_len == CNT_ZERO) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bit_ready) begin
          // A handshake always completes, even alongside abort.
          lfsr_s = next_lfsr_s;
          cnt_s  = cnt_r - CNT_ONE;
          wrap_s = (next_lfsr_s == start_val_r);
          if (cnt_r == CNT_ONE) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else if (abort) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_RUN;
          end
        end else if (abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered flag outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= SEED;
      start_val_r <= SEED;
      cnt_r       <= CNT_ZERO;
      done_r      <= 1'b0;
      wrap_r      <= 1'b0;
      seed_err_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      lfsr_r      <= lfsr_s;
      start_val_r <= start_val_s;
      cnt_r       <= cnt_s;
      done_r      <= done_s;
      wrap_r      <= wrap_s;
      seed_err_r  <= seed_err_s;
    end
  end

  // bit_out is gated by valid so it reads 0 whenever no bit is offered.
  assign bit_valid  = (state_r == ST_RUN);
  assign bit_out    = bit_valid & lfsr_r[WIDTH-1];
  assign busy       = (state_r != ST_IDLE);
  assign done       = done_r;
  assign wrap       = wrap_r;
  assign seed_err   = seed_err_r;
  assign lfsr_state = lfsr_r;

endmodule
